// File: rtl/bloom_table_writer.sv
// Write side of the censor Bloom filter: owns the 32x32-bit table, sets bits from
// hash pairs, runs a 32-cycle word-by-word clear and exports the whole table.
module bloom_table_writer #(
  parameter int TABLE_BITS = 1024,
  parameter bit PRELOAD    = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  input  logic [9:0]            ins_hash1,
  input  logic [9:0]            ins_hash2,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      word_count,
  output logic [TABLE_BITS-1:0] table_out
);

  localparam int WORDS = TABLE_BITS / 32;

  function automatic logic [TABLE_BITS-1:0] reset_image();
    logic [TABLE_BITS-1:0] img;
    img = '0;
    if (PRELOAD) begin
      img[101] = 1'b1;
      img[165] = 1'b1;
      img[244] = 1'b1;
      img[471] = 1'b1;
    end
    return img;
  endfunction

  localparam logic [TABLE_BITS-1:0] RESET_IMAGE = reset_image();
  localparam logic [CNT_W-1:0]      RESET_COUNT = PRELOAD ? CNT_W'(2) : '0;

  typedef enum logic [1:0] {IDLE, SET1, SET2, CLEAR} state_t;

  state_t           state_reg, state_next;
  logic             clear_pend_reg, clear_pend_next;
  logic [4:0]       word_idx_reg, word_idx_next;
  logic [9:0]       hash1_reg, hash2_reg;
  logic             latch_hashes;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             done_reg, done_next;
  logic             set_en;
  logic [9:0]       set_idx;

  always_comb begin
    state_next      = state_reg;
    clear_pend_next = clear_pend_reg;
    word_idx_next   = word_idx_reg;
    count_next      = count_reg;
    done_next       = 1'b0;
    latch_hashes    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clear || clear_pend_reg) begin
          state_next      = CLEAR;
          word_idx_next   = '0;
          clear_pend_next = 1'b0;
        end else if (ins_valid && ins_ready) begin
          latch_hashes = 1'b1;
          state_next   = SET1;
        end
      end
      SET1: begin
        state_next = SET2;
        if (clear) clear_pend_next = 1'b1;
      end
      SET2: begin
        state_next = IDLE;
        done_next  = 1'b1;
        if (clear) clear_pend_next = 1'b1;
        if (count_reg != '1) count_next = count_reg + CNT_W'(1);
      end
      CLEAR: begin
        // Clear requests arriving mid-sweep are deliberately dropped.
        word_idx_next = word_idx_reg + 5'd1;
        if (word_idx_reg == 5'd31) begin
          state_next = IDLE;
          count_next = '0;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      clear_pend_reg <= 1'b0;
      word_idx_reg   <= '0;
      hash1_reg      <= '0;
      hash2_reg      <= '0;
      count_reg      <= RESET_COUNT;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clear_pend_reg <= clear_pend_next;
      word_idx_reg   <= word_idx_next;
      count_reg      <= count_next;
      done_reg       <= done_next;
      if (latch_hashes) begin
        hash1_reg <= ins_hash1;
        hash2_reg <= ins_hash2;
      end
    end
  end

  assign set_en  = (state_reg == SET1) || (state_reg == SET2);
  assign set_idx = (state_reg == SET1) ? hash1_reg : hash2_reg;

  // One register per table word so the reset image and the clear sweep stay per-word.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      logic [31:0] word_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg <= RESET_IMAGE[32*gi +: 32];
        end else if (state_reg == CLEAR && word_idx_reg == 5'(gi)) begin
          word_reg <= '0;
        end else if (set_en && set_idx[9:5] == 5'(gi)) begin
          word_reg[set_idx[4:0]] <= 1'b1;
        end
      end
      assign table_out[32*gi +: 32] = word_reg;
    end
  endgenerate

  assign ins_ready  = rst_n && (state_reg == IDLE) && !clear && !clear_pend_reg;
  assign busy       = (state_reg != IDLE) || clear_pend_reg;
  assign done       = done_reg;
  assign word_count = count_reg;

endmodule

// File: tb/tb_bloom_table_writer.sv
// Randomised and directed bench for bloom_table_writer against a timeline model
// that schedules each insert/clear by edge number.
module tb_bloom_table_writer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          ins_valid;
  logic          ins_ready;
  logic [9:0]    ins_hash1;
  logic [9:0]    ins_hash2;
  logic          busy;
  logic          done;
  logic [7:0]    word_count;
  logic [1023:0] table_out;

  bloom_table_writer #(.TABLE_BITS(1024), .PRELOAD(1'b1), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins_hash1  (ins_hash1),
    .ins_hash2  (ins_hash2),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .table_out  (table_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: an operation occupies edges start+1 .. end; idle once end < edge_n.
  logic [1023:0] m_tab;
  int            m_cnt;
  bit            m_done;
  bit            m_pend;
  bit            m_is_clear;
  int            m_start;
  int            m_end;
  int            edge_n;
  logic [9:0]    m_h1, m_h2;

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    int d;
    checks++;
    if (got !== exp) begin
      errors++;
      if ((got >> 128) == '0 && (exp >> 128) == '0) begin
        $display("FAIL %s cyc %0d got %0h exp %0h", tag, cyc, got[127:0], exp[127:0]);
      end else begin
        d = 0;
        while (d < 1023 && got[d] === exp[d]) d++;
        $display("FAIL %s cyc %0d first diff bit %0d got %b exp %b", tag, cyc, d, got[d], exp[d]);
      end
    end
  endtask

  task automatic model_reset();
    m_tab = '0;
    m_tab[101] = 1'b1;
    m_tab[165] = 1'b1;
    m_tab[244] = 1'b1;
    m_tab[471] = 1'b1;
    m_cnt      = 2;
    m_done     = 1'b0;
    m_pend     = 1'b0;
    m_is_clear = 1'b0;
    m_end      = edge_n - 1;
    m_start    = edge_n - 1;
  endtask

  task automatic model_edge(input bit c, input bit v, input logic [9:0] a,
                            input logic [9:0] b, input bit rdy);
    int w;
    m_done = 1'b0;
    if (m_end < edge_n) begin
      if (c || m_pend) begin
        m_is_clear = 1'b1;
        m_start    = edge_n;
        m_end      = edge_n + 32;
        m_pend     = 1'b0;
      end else if (v && rdy) begin
        m_is_clear = 1'b0;
        m_start    = edge_n;
        m_end      = edge_n + 2;
        m_h1       = a;
        m_h2       = b;
      end
    end else if (!m_is_clear) begin
      if (edge_n == m_start + 1) begin
        m_tab[m_h1] = 1'b1;
      end else begin
        m_tab[m_h2] = 1'b1;
        if (m_cnt != 255) m_cnt++;
        m_done = 1'b1;
      end
      if (c) m_pend = 1'b1;
    end else begin
      w = edge_n - m_start - 1;
      m_tab[w*32 +: 32] = '0;
      if (edge_n == m_end) begin
        m_cnt  = 0;
        m_done = 1'b1;
      end
    end
    edge_n++;
  endtask

  task automatic check_outputs();
    chk("table_out", table_out, m_tab);
    chk("word_count", 1024'(word_count), 1024'(m_cnt));
    chk("done", 1024'(done), 1024'(m_done));
    chk("busy", 1024'(busy), 1024'((m_end >= edge_n) || m_pend));
  endtask

  // One clock cycle: drive at negedge, check ready, model the edge, check outputs.
  task automatic step(input bit c, input bit v, input logic [9:0] a, input logic [9:0] b,
                      output bit accepted);
    bit rdy;
    @(negedge clk);
    clear     = c;
    ins_valid = v;
    ins_hash1 = a;
    ins_hash2 = b;
    #1;
    rdy = (m_end < edge_n) && !c && !m_pend;
    chk("ins_ready", 1024'(ins_ready), 1024'(rdy));
    @(posedge clk);
    model_edge(c, v, a, b, rdy);
    cyc++;
    #1;
    check_outputs();
    accepted = v && rdy;
  endtask

  task automatic idle_cycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 10'd0, 10'd0, acc);
  endtask

  initial begin
    bit acc;
    int n_xfer;
    int guard;
    logic [9:0] a, b;

    edge_n    = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    ins_valid = 1'b0;
    ins_hash1 = '0;
    ins_hash2 = '0;
    model_reset();

    // Reset state, sampled while reset is still asserted.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_table", table_out, m_tab);
    chk("rst_count", 1024'(word_count), 1024'(2));
    chk("rst_busy", 1024'(busy), 1024'(0));
    chk("rst_done", 1024'(done), 1024'(0));
    chk("rst_ready", 1024'(ins_ready), 1024'(0));
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 1024'(ins_ready), 1024'(1));

    idle_cycles(2);

    // Single insert 5/1000.
    step(1'b0, 1'b1, 10'd5, 10'd1000, acc);
    chk("ins_5_1000_accepted", 1024'(acc), 1024'(1));
    idle_cycles(4);
    chk("ins_count_3", 1024'(word_count), 1024'(3));

    // Bulk clear.
    step(1'b1, 1'b0, 10'd0, 10'd0, acc);
    idle_cycles(34);
    chk("clear_zero", table_out, '0);

    // Clear and insert in the same idle cycle: insert must be refused.
    step(1'b1, 1'b1, 10'd7, 10'd8, acc);
    chk("clr_ins_refused", 1024'(acc), 1024'(0));
    idle_cycles(34);
    chk("bits_7_8_zero", 1024'(table_out[8:7]), 1024'(0));

    // Clear during SET1 of insert 33/34.
    step(1'b0, 1'b1, 10'd33, 10'd34, acc);
    step(1'b1, 1'b0, 10'd0, 10'd0, acc);
    idle_cycles(36);
    chk("pend_clear_zero", table_out, '0);

    // Held ins_valid, 300 transfers cycling 31/32, 63/64, 31/31.
    n_xfer = 0;
    guard  = 0;
    while (n_xfer < 300 && guard < 3000) begin
      case (n_xfer % 3)
        0:       begin a = 10'd31; b = 10'd32; end
        1:       begin a = 10'd63; b = 10'd64; end
        default: begin a = 10'd31; b = 10'd31; end
      endcase
      step(1'b0, 1'b1, a, b, acc);
      if (acc) n_xfer++;
      guard++;
    end
    chk("sat_xfers", 1024'(n_xfer), 1024'(300));
    idle_cycles(3);
    chk("sat_count", 1024'(word_count), 1024'(255));
    chk("sat_bits", 1024'({table_out[64:63], table_out[32:31]}), 1024'(4'hF));

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 40) == 0), $urandom_range(0, 1) == 1,
           10'($urandom), 10'($urandom), acc);
    end
    idle_cycles(40);

    // Asynchronous reset in the middle of a clear sweep (word_idx = 10).
    step(1'b0, 1'b1, 10'd900, 10'd1023, acc);
    idle_cycles(3);
    step(1'b1, 1'b0, 10'd0, 10'd0, acc);
    idle_cycles(10);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midclr_rst_table", table_out, m_tab);
    chk("midclr_rst_busy", 1024'(busy), 1024'(0));
    chk("midclr_rst_count", 1024'(word_count), 1024'(2));
    chk("midclr_rst_ready", 1024'(ins_ready), 1024'(0));
    #1;
    rst_n = 1'b1;
    idle_cycles(3);
    step(1'b0, 1'b1, 10'd500, 10'd2, acc);
    idle_cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
